// File: rtl/mult_pkg.sv
// Shared types and default sizes for the mult_8 downstream accumulator stage.
package mult_pkg;

    // Two-state sequence control: accumulating terms, or presenting a result
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int MULT_ACC_W = 24;
    localparam int MULT_CNT_W = 8;

endpackage : mult_pkg

// File: rtl/mult_acc_if.sv
// Product-beat input channel and valid/ready result channel of mult_acc.
interface mult_acc_if
    import mult_pkg::*;
#(
    parameter int ACC_W = MULT_ACC_W,
    parameter int CNT_W = MULT_CNT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       prod_lo;
    logic [7:0]       prod_hi;
    logic             in_last;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] term_cnt;
    logic             ovf;

    // Producer of beats and consumer of results
    modport master (
        output in_valid, prod_lo, prod_hi, in_last, clear, out_ready,
        input  in_ready, out_valid, acc_out, term_cnt, ovf
    );

    // The accumulator stage itself
    modport slave (
        input  in_valid, prod_lo, prod_hi, in_last, clear, out_ready,
        output in_ready, out_valid, acc_out, term_cnt, ovf
    );

endinterface : mult_acc_if

// File: rtl/sat_add.sv
// W-bit unsigned adder with carry out; optionally clamps to all-ones on carry.
module sat_add #(
    parameter int W   = 24,
    parameter bit SAT = 1'b1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);

    logic [W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[W];
    assign o_sum   = (SAT && o_carry) ? '1 : w_full[W-1:0];

endmodule : sat_add

// File: rtl/mult_acc.sv
// Accumulates 16-bit products into a wide sum, closes on in_last and
// presents sum/term count/overflow until the consumer takes it.
module mult_acc
    import mult_pkg::*;
#(
    parameter int ACC_W = MULT_ACC_W,
    parameter int CNT_W = MULT_CNT_W,
    parameter bit SAT   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    mult_acc_if.slave   bus
);

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_ovf, w_ovf_nxt;

    logic [ACC_W-1:0]   w_prod;
    logic [ACC_W-1:0]   w_acc_base;
    logic [CNT_W-1:0]   w_cnt_base;
    logic               w_ovf_base;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;
    logic               w_accept;

    assign w_prod   = {{(ACC_W-16){1'b0}}, bus.prod_hi, bus.prod_lo};
    assign w_accept = bus.in_valid && (r_state == ACCUM);

    // A clear arriving with a beat restarts the sequence from that beat,
    // so the adder operand and the sticky bits fall back to zero first.
    assign w_acc_base = bus.clear ? '0   : r_acc;
    assign w_cnt_base = bus.clear ? '0   : r_cnt;
    assign w_ovf_base = bus.clear ? 1'b0 : r_ovf;

    sat_add #(
        .W   (ACC_W),
        .SAT (SAT)
    ) u_sat_add (
        .i_a     (w_acc_base),
        .i_b     (w_prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Next-state, next-register values and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_ovf_nxt     = r_ovf;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (w_accept) begin
                    w_acc_nxt = w_sum;
                    w_ovf_nxt = w_ovf_base | w_carry;
                    w_cnt_nxt = (w_cnt_base == '1) ? w_cnt_base
                                                   : w_cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (bus.in_last) begin
                        w_state_nxt = HOLD;
                    end
                end else if (bus.clear) begin
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                    w_ovf_nxt = 1'b0;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // State and accumulator registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign bus.acc_out  = r_acc;
    assign bus.term_cnt = r_cnt;
    assign bus.ovf      = r_ovf;

endmodule : mult_acc

// File: tb/tb_mult_acc.sv
// Bench for mult_acc: a saturating and a wrapping instance driven in lockstep,
// expected results queued as sequences close and checked at out_valid.
module tb_mult_acc;

    typedef struct {
        logic [23:0] acc_s;
        logic [23:0] acc_w;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    longint m_sum;
    int     m_cnt;

    mult_acc_if #(.ACC_W(24), .CNT_W(8)) ifs ();
    mult_acc_if #(.ACC_W(24), .CNT_W(8)) ifw ();

    mult_acc #(.ACC_W(24), .CNT_W(8), .SAT(1'b1)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    mult_acc #(.ACC_W(24), .CNT_W(8), .SAT(1'b0)) u_dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (ifw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [15:0] p, input logic last,
                         input logic clr, input logic ordy);
        ifs.in_valid = v;  ifw.in_valid = v;
        ifs.prod_lo = p[7:0];  ifw.prod_lo = p[7:0];
        ifs.prod_hi = p[15:8]; ifw.prod_hi = p[15:8];
        ifs.in_last = last; ifw.in_last = last;
        ifs.clear = clr; ifw.clear = clr;
        ifs.out_ready = ordy; ifw.out_ready = ordy;
    endtask

    task automatic model_reset();
        m_sum = 0;
        m_cnt = 0;
    endtask

    task automatic push_expected();
        exp_t e;
        logic [63:0] s;
        s = m_sum;
        e.ovf   = (m_sum >= 64'h100_0000);
        e.acc_s = e.ovf ? 24'hFF_FFFF : s[23:0];
        e.acc_w = s[23:0];
        e.cnt   = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
        sb.push_back(e);
    endtask

    // One accepted beat; the stage must be ready for it
    task automatic beat(input logic [15:0] p, input logic last, input logic clr);
        @(negedge clk);
        n_checks++;
        if (ifs.in_ready !== 1'b1 || ifw.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL beat_ready: got sat=%b wrap=%b want 1", ifs.in_ready, ifw.in_ready);
        end
        drive(1'b1, p, last, clr, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        if (clr) model_reset();
        m_sum += longint'(p);
        m_cnt++;
        if (last) push_expected();
    endtask

    task automatic clear_only();
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
    endtask

    // Wait for the result, compare against the scoreboard, optionally stall
    // (with clear and a stray beat applied), then take it and check the restart.
    task automatic check_result(input string name, input int stall, input logic poke);
        int   waited;
        exp_t e;
        logic [23:0] held;
        waited = 0;
        @(negedge clk);
        while (ifs.out_valid !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited != 0) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d extra cycles want 0", name, waited);
            if (ifs.out_valid !== 1'b1) return;
        end
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s_scoreboard: got empty queue want entry", name);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (ifs.acc_out !== e.acc_s || ifs.term_cnt !== e.cnt || ifs.ovf !== e.ovf) begin
            n_errors++;
            $display("FAIL %s_sat: got acc=%h cnt=%0d ovf=%b want acc=%h cnt=%0d ovf=%b",
                     name, ifs.acc_out, ifs.term_cnt, ifs.ovf, e.acc_s, e.cnt, e.ovf);
        end
        n_checks++;
        if (ifw.acc_out !== e.acc_w || ifw.term_cnt !== e.cnt || ifw.ovf !== e.ovf ||
            ifw.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_wrap: got v=%b acc=%h cnt=%0d ovf=%b want v=1 acc=%h cnt=%0d ovf=%b",
                     name, ifw.out_valid, ifw.acc_out, ifw.term_cnt, ifw.ovf, e.acc_w, e.cnt, e.ovf);
        end
        held = ifs.acc_out;
        for (int i = 0; i < stall; i++) begin
            drive(poke, 16'hAAAA, poke, poke, 1'b0);
            @(negedge clk);
            n_checks++;
            if (ifs.out_valid !== 1'b1 || ifs.in_ready !== 1'b0 || ifs.acc_out !== held ||
                ifs.term_cnt !== e.cnt || ifs.ovf !== e.ovf) begin
                n_errors++;
                $display("FAIL %s_stall%0d: got v=%b rdy=%b acc=%h cnt=%0d want v=1 rdy=0 acc=%h cnt=%0d",
                         name, i, ifs.out_valid, ifs.in_ready, ifs.acc_out, ifs.term_cnt, held, e.cnt);
            end
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        n_checks++;
        if (ifs.out_valid !== 1'b0 || ifs.in_ready !== 1'b1 || ifs.acc_out !== 24'h0 ||
            ifs.term_cnt !== 8'h0 || ifs.ovf !== 1'b0 || ifw.acc_out !== 24'h0 || ifw.ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_take: got v=%b rdy=%b acc=%h cnt=%0d ovf=%b want v=0 rdy=1 acc=0 cnt=0 ovf=0",
                     name, ifs.out_valid, ifs.in_ready, ifs.acc_out, ifs.term_cnt, ifs.ovf);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        n_checks++;
        if (ifs.out_valid !== 1'b0 || ifs.acc_out !== 24'h0 || ifs.term_cnt !== 8'h0 ||
            ifs.ovf !== 1'b0 || ifw.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b acc=%h cnt=%0d ovf=%b want v=0 acc=0 cnt=0 ovf=0",
                     ifs.out_valid, ifs.acc_out, ifs.term_cnt, ifs.ovf);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifs.in_ready !== 1'b1 || ifs.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", ifs.in_ready, ifs.out_valid);
        end
    endtask

    task automatic test_basic();
        beat(16'h0003, 1'b0, 1'b0);
        beat(16'h0010, 1'b0, 1'b0);
        beat(16'h0100, 1'b1, 1'b0);
        check_result("basic", 0, 1'b0);
    endtask

    task automatic test_hold_stall();
        beat(16'h0003, 1'b0, 1'b0);
        beat(16'h0010, 1'b0, 1'b0);
        beat(16'h0100, 1'b1, 1'b0);
        check_result("hold_clear", 5, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 257; i++) begin
            beat(16'hFFFF, (i == 256), 1'b0);
        end
        check_result("overflow", 0, 1'b0);
    endtask

    task automatic test_clear();
        beat(16'h0050, 1'b0, 1'b0);
        beat(16'h0020, 1'b0, 1'b0);
        clear_only();
        beat(16'h0007, 1'b1, 1'b0);
        check_result("clear_idle", 0, 1'b0);
        beat(16'h0050, 1'b0, 1'b0);
        beat(16'hFFFF, 1'b0, 1'b0);
        beat(16'h0009, 1'b1, 1'b1);
        check_result("clear_beat", 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        beat(16'h0011, 1'b0, 1'b0);
        beat(16'h0022, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (ifs.out_valid !== 1'b0 || ifs.acc_out !== 24'h0 || ifs.term_cnt !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_mid_seq: got v=%b acc=%h cnt=%0d want v=0 acc=0 cnt=0",
                     ifs.out_valid, ifs.acc_out, ifs.term_cnt);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        beat(16'h0005, 1'b0, 1'b0);
        beat(16'h0006, 1'b1, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (ifs.out_valid !== 1'b0 || ifw.out_valid !== 1'b0 || ifs.acc_out !== 24'h0 ||
            ifs.term_cnt !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_mid_hold: got v=%b acc=%h cnt=%0d want v=0 acc=0 cnt=0",
                     ifs.out_valid, ifs.acc_out, ifs.term_cnt);
        end
        if (sb.size() != 0) void'(sb.pop_back());
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        beat(16'h1234, 1'b1, 1'b0);
        check_result("single_after_reset", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        beat(16'hFF00, 1'b1, 1'b0);
        check_result("b2b_a", 0, 1'b0);
        beat(16'h8001, 1'b0, 1'b0);
        beat(16'h7FFF, 1'b1, 1'b0);
        check_result("b2b_b", 0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_hold_stall();
        test_overflow();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mult_acc

// File: doc/mult_acc.md
Name: mult_acc

Overview:
- Downstream stage of the 8x8 bit-serial multiplier (mult_8).
- Consumes each finished 16-bit product, presented as a low byte and a high byte, and accumulates products into a wide register for dot-product / MAC use.
- Closes a sequence on a last-term flag, then presents the sum, term count and overflow flag on a valid/ready output.
- Auto-clears when the result is taken.

Parameters:
- ACC_W, 24, accumulator width in bits (>=17).
- CNT_W, 8, term counter width.
- SAT, 1, 1 = saturate on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  stage can accept a beat.
- prod_lo  in  8  product bits [7:0] (mult8).
- prod_hi  in  8  product bits [15:8] (mult16).
- in_last  in  1  beat is the final term of the sequence.
- clear  in  1  synchronous abort/clear of the running sequence.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- acc_out  out  ACC_W  accumulated sum.
- term_cnt  out  CNT_W  number of terms accumulated.
- ovf  out  1  sticky overflow flag for the sequence.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - out_valid=0, in_ready=1 (once reset is released).
- Beat accept: a beat is accepted when in_valid & in_ready.
  - prod = {prod_hi, prod_lo}, zero-extended to ACC_W.
- State ACCUM: in_ready=1, out_valid=0.
  - On accept: sum = acc + prod computed ACC_W+1 wide.
  - If carry out: ovf<=1 (sticky); acc<=all-ones if SAT=1, else acc<=sum[ACC_W-1:0].
  - Otherwise acc<=sum.
  - cnt<=cnt+1, saturating at 2^CNT_W-1; no wrap.
  - If in_last on the accepted beat: next state HOLD.
- State HOLD: in_ready=0, out_valid=1.
  - acc_out, term_cnt and ovf stay stable until out_ready=1.
  - On out_valid & out_ready: acc<=0, cnt<=0, ovf<=0, next state ACCUM. in_ready=1 from the following cycle.
- Latency: last beat accepted in cycle N -> out_valid=1 in cycle N+1 with the final sum. Minimum of one idle input cycle between sequences.
- acc_out, term_cnt and ovf are registered and always reflect the live registers; they are only meaningful while out_valid=1.
- clear in ACCUM:
  - Without a beat: acc, cnt and ovf are zeroed next cycle.
  - With a beat in the same cycle: the accumulator restarts from that beat (acc<=prod, cnt<=1, ovf<=0). If that beat has in_last=1, go to HOLD.
- clear in HOLD: ignored; a presented result is never destroyed.
- in_last with in_valid=0: ignored.
- Asynchronous reset mid-sequence or mid-HOLD: drops all state immediately; out_valid falls to 0 asynchronously.
- Single-term sequence (first beat has in_last=1): result = that product, cnt=1.

Decomposition:
- Package mult_pkg holds:
  - state enum {ACCUM, HOLD}.
  - Default constants MULT_ACC_W=24 and MULT_CNT_W=8.
- One sub-module: sat_add, a combinational ACC_W adder with carry out and SAT-controlled clamp. It is reusable by later MAC stages.
- The FSM and registers live in mult_acc.

Test Plan:
- Reset then beats 0x0003, 0x0010, 0x0100 (last) -> out_valid next cycle; acc_out=0x000113, term_cnt=3, ovf=0.
- Hold out_ready=0 for 5 cycles after result -> out_valid stays 1, in_ready=0, outputs stable; out_ready=1 -> next cycle in_ready=1, acc=0.
- SAT=1: 257 beats of 0xFFFF (last on 257th) -> acc_out=0xFFFFFF, ovf=1, term_cnt=255. SAT=0: same stimulus -> acc_out=0x00FEFF, ovf=1.
- clear with no beat after 0x0050, 0x0020 -> next beat 0x0007 (last) yields acc_out=0x000007, term_cnt=1. clear concurrent with beat 0x0009 -> acc=0x000009, cnt=1.
- clear asserted during HOLD with acc_out=0x000113 -> result unchanged until out_ready handshake.
- Assert reset low mid-sequence after 2 beats -> out_valid=0, acc=0, cnt=0 immediately; after release, single beat 0x1234 (last) -> acc_out=0x001234, term_cnt=1.
